// File: rtl/column_neighbor_reader.sv
// column_neighbor_reader
//   Read side of the per-column u/v M10K storage. Sweeps rows 0..NUM_ROWS-1 of
//   one column, keeps a three-row window of u (and two rows of v) and streams
//   one record per row with the cell's u_curr, v_next and its top (row-1) and
//   bottom (row+1) u neighbours. Rows outside the column read as BOUNDARY.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   start               one-cycle sweep request, honoured only when idle
//   read_addr           shared read address to the u_curr and v_next M10Ks
//   read_data_u/_v      M10K q outputs (valid the cycle after the address edge)
//   out_valid/out_ready record handshake towards diffusion_solver
//   out_u_curr/top/bottom, out_v_next, out_row, out_last  record fields
//   busy                sweep in progress
//   done                one-cycle pulse after the last record is accepted
//
// States
//   IDLE    | waiting for start
//   ISSUE   | read_addr held for the M10K to sample
//   CAPTURE | M10K q shifted into the window
//   TAIL    | bottom boundary shifted in after the last row (no read)
//   EMIT    | record presented, waiting for out_ready
//   DONE    | done pulse, back to IDLE
module column_neighbor_reader #(
  parameter int                NUM_ROWS = 11,
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 18,
  parameter logic [DATA_W-1:0] BOUNDARY = 18'h04000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data_u,
  input  logic [DATA_W-1:0] read_data_v,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_u_curr,
  output logic [DATA_W-1:0] out_u_top,
  output logic [DATA_W-1:0] out_u_bottom,
  output logic [DATA_W-1:0] out_v_next,
  output logic [ADDR_W-1:0] out_row,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    TAIL,
    EMIT,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ROWS - 1);
  localparam logic [ADDR_W:0]   ROWS_EXT  = (ADDR_W+1)'(NUM_ROWS);
  localparam bit                MULTI_ROW = (NUM_ROWS > 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] row_q;
  logic [DATA_W-1:0] u_top_q, u_mid_q, u_bot_q;
  logic [DATA_W-1:0] v_mid_q, v_bot_q;
  logic              valid_q, last_q, busy_q, done_q;

  // Next fetch address with a carry bit so the bound compare cannot wrap.
  logic [ADDR_W:0] addr_inc_ext;
  assign addr_inc_ext = {1'b0, addr_q} + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      row_q   <= '0;
      u_top_q <= '0;
      u_mid_q <= '0;
      u_bot_q <= '0;
      v_mid_q <= '0;
      v_bot_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            // Pre-loading BOUNDARY makes row 0's top neighbour fall out of
            // the normal shift.
            u_mid_q <= BOUNDARY;
            u_bot_q <= BOUNDARY;
            v_mid_q <= '0;
            v_bot_q <= '0;
            addr_q  <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          u_top_q <= u_mid_q;
          u_mid_q <= u_bot_q;
          u_bot_q <= read_data_u;
          v_mid_q <= v_bot_q;
          v_bot_q <= read_data_v;
          if (addr_q == '0) begin
            // Row 0 alone does not fill the window; fetch row 1 first.
            if (MULTI_ROW) begin
              addr_q  <= ADDR_W'(1);
              state_q <= ISSUE;
            end else begin
              state_q <= TAIL;
            end
          end else begin
            valid_q <= 1'b1;
            last_q  <= (row_q == LAST_ROW);
            state_q <= EMIT;
          end
        end
        TAIL: begin
          u_top_q <= u_mid_q;
          u_mid_q <= u_bot_q;
          u_bot_q <= BOUNDARY;
          v_mid_q <= v_bot_q;
          v_bot_q <= '0;
          valid_q <= 1'b1;
          last_q  <= (row_q == LAST_ROW);
          state_q <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (row_q == LAST_ROW) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              row_q <= row_q + ADDR_W'(1);
              if (addr_inc_ext < ROWS_EXT) begin
                addr_q  <= addr_inc_ext[ADDR_W-1:0];
                state_q <= ISSUE;
              end else begin
                state_q <= TAIL;
              end
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign read_addr    = addr_q;
  assign out_valid    = valid_q;
  assign out_u_top    = u_top_q;
  assign out_u_curr   = u_mid_q;
  assign out_u_bottom = u_bot_q;
  assign out_v_next   = v_mid_q;
  assign out_row      = row_q;
  assign out_last     = last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
